// File: rtl/rvm_mem_arbiter_if.sv
// Request, completion and shared-memory-bus signals of rvm_mem_arbiter.
// slave: arbiter side; master: requesters plus memory model side.
interface rvm_mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic        i_done;
  logic [31:0] i_rdata;
  logic        i_err;

  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_ben;
  logic        d_wen;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_err;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_ben;
  logic        mem_wen;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        mem_error;

  modport slave (
    input  i_req, i_addr,
    output i_done, i_rdata, i_err,
    input  d_req, d_addr, d_wdata, d_ben, d_wen,
    output d_done, d_rdata, d_err,
    output mem_addr, mem_wdata, mem_ben, mem_wen,
    input  mem_rdata, mem_stall, mem_error
  );

  modport master (
    output i_req, i_addr,
    input  i_done, i_rdata, i_err,
    output d_req, d_addr, d_wdata, d_ben, d_wen,
    input  d_done, d_rdata, d_err,
    input  mem_addr, mem_wdata, mem_ben, mem_wen,
    output mem_rdata, mem_stall, mem_error
  );
endinterface

// File: rtl/rvm_mem_arbiter.sv
// Fetch/data arbiter for the shared SRAM bus, with stall watchdog.
// Ports: clk, resetn (async low), arb (rvm_mem_arbiter_if.slave).
// RVM_ARB_ROUND_ROBIN_EN: round-robin on ties, else data wins.
module rvm_mem_arbiter #(
  parameter int STALL_LIMIT = 64,
  parameter int CW          = 8
) (
  input  logic              clk,
  input  logic              resetn,
  rvm_mem_arbiter_if.slave  arb
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_e;

  localparam logic [CW-1:0] LIM = CW'(STALL_LIMIT);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    ben_q, ben_d;
  logic          wen_q, wen_d;
  logic          gnt_d;
  logic          tmo;
  logic          fin;

`ifdef RVM_ARB_ROUND_ROBIN_EN
  logic last_d_q, last_d_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) last_d_q <= 1'b1;
    else         last_d_q <= last_d_d;
  end

  // On a tie, the port not served last time wins.
  assign gnt_d = arb.d_req && (!arb.i_req || !last_d_q);
`else
  assign gnt_d = arb.d_req;
`endif

  // Watchdog fires when the stall has lasted STALL_LIMIT cycles.
  assign tmo = (STALL_LIMIT != 0) && arb.mem_stall && (cnt_q == LIM);
  assign fin = !arb.mem_stall || tmo;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ben_q   <= '0;
      wen_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ben_q   <= ben_d;
      wen_q   <= wen_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    ben_d       = ben_q;
    wen_d       = wen_q;
`ifdef RVM_ARB_ROUND_ROBIN_EN
    last_d_d    = last_d_q;
`endif
    arb.i_done  = 1'b0;
    arb.i_err   = 1'b0;
    arb.i_rdata = '0;
    arb.d_done  = 1'b0;
    arb.d_err   = 1'b0;
    arb.d_rdata = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (gnt_d) begin
          addr_d  = arb.d_addr;
          wdata_d = arb.d_wdata;
          ben_d   = arb.d_ben;
          wen_d   = arb.d_wen;
          state_d = BUSY_D;
`ifdef RVM_ARB_ROUND_ROBIN_EN
          last_d_d = 1'b1;
`endif
        end else if (arb.i_req) begin
          addr_d  = arb.i_addr;
          wdata_d = '0;
          ben_d   = 4'b1111;
          wen_d   = 1'b0;
          state_d = BUSY_I;
`ifdef RVM_ARB_ROUND_ROBIN_EN
          last_d_d = 1'b0;
`endif
        end
      end
      BUSY_I: begin
        if (fin) begin
          arb.i_done  = 1'b1;
          arb.i_err   = tmo | arb.mem_error;
          arb.i_rdata = tmo ? 32'h0 : arb.mem_rdata;
          state_d     = IDLE;
          ben_d       = '0;
          wen_d       = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BUSY_D: begin
        if (fin) begin
          arb.d_done  = 1'b1;
          arb.d_err   = tmo | arb.mem_error;
          arb.d_rdata = tmo ? 32'h0 : arb.mem_rdata;
          state_d     = IDLE;
          ben_d       = '0;
          wen_d       = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        ben_d   = '0;
        wen_d   = 1'b0;
      end
    endcase
  end

  assign arb.mem_addr  = addr_q;
  assign arb.mem_wdata = wdata_q;
  assign arb.mem_ben   = ben_q;
  assign arb.mem_wen   = wen_q;

endmodule
